// File: rtl/cmac_tx_pkg.sv
// Shared constants for the CMAC TX arbiter: default bus widths, grant encoding, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmac_tx_pkg;

   // Default AXIS widths for the 100G CMAC user interface.
   localparam int AXIS_DATA_W = 512;
   localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

   // One-hot grant encoding: bit0 = s0 (ERNIC), bit1 = s1 (packet generator).
   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_S0   = 2'b01;
   localparam logic [1:0] GNT_S1   = 2'b10;

   // State codes match the grant encoding so the grant register mirrors the state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_t;

endpackage

// File: rtl/cmac_tx_axis_arb_if.sv
// AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast/tuser) used on every arbiter port.
// Latency: n/a (wiring only).
// Backpressure: tready flows from slave to master.
interface cmac_tx_axis_arb_if
   import cmac_tx_pkg::*;
#(
   parameter int DATA_W = AXIS_DATA_W,
   parameter int KEEP_W = AXIS_KEEP_W
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic              tuser;

   modport master (
      output tvalid, tdata, tkeep, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/cmac_tx_rr_pick.sv
// Two-request select: fixed priority (s0 first) or round-robin against the last-granted source.
// Latency: purely combinational.
// Backpressure: none; only looks at request lines.
module cmac_tx_rr_pick
   import cmac_tx_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  logic       prio_mode,
   input  logic       last_s1,
   output logic [1:0] pick
);

   // A tie goes to s0 in priority mode, otherwise to whichever source was not served last.
   always_comb begin
      pick = GNT_NONE;
      if (req0 && req1) begin
         pick = (prio_mode || last_s1) ? GNT_S0 : GNT_S1;
      end else if (req0) begin
         pick = GNT_S0;
      end else if (req1) begin
         pick = GNT_S1;
      end
   end

endmodule

// File: rtl/cmac_tx_axis_arb.sv
// Packet-level 2:1 AXIS arbiter (ERNIC s0, packet generator s1) feeding CMAC tx_axis.
// Latency: grant one cycle after tvalid seen in IDLE; data path is a zero-latency pass-through.
// Backpressure: m_axis.tready goes straight to the granted source; non-granted/idle tready is 0.
module cmac_tx_axis_arb
   import cmac_tx_pkg::*;
#(
   parameter int DATA_W = AXIS_DATA_W,
   parameter int KEEP_W = AXIS_KEEP_W,
   parameter int CNT_W  = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   tx_enable,
   input  logic                   prio_mode,
   cmac_tx_axis_arb_if.slave      s0_axis,
   cmac_tx_axis_arb_if.slave      s1_axis,
   cmac_tx_axis_arb_if.master     m_axis,
   output logic [1:0]             grant,
   output logic [CNT_W-1:0]       pkt_cnt0,
   output logic [CNT_W-1:0]       pkt_cnt1
);

   arb_state_t        state;
   logic              last_s1;
   logic [1:0]        pick;

   logic              mux_tvalid;
   logic [DATA_W-1:0] mux_tdata;
   logic [KEEP_W-1:0] mux_tkeep;
   logic              mux_tlast;
   logic              mux_tuser;
   logic              s0_rdy;
   logic              s1_rdy;
   logic              tlast_acc;

   cmac_tx_rr_pick u_pick (
      .req0      (s0_axis.tvalid),
      .req1      (s1_axis.tvalid),
      .prio_mode (prio_mode),
      .last_s1   (last_s1),
      .pick      (pick)
   );

   // Route the owner's stream to the CMAC; everything is held at zero while idle.
   always_comb begin
      mux_tvalid = 1'b0;
      mux_tdata  = '0;
      mux_tkeep  = '0;
      mux_tlast  = 1'b0;
      mux_tuser  = 1'b0;
      s0_rdy     = 1'b0;
      s1_rdy     = 1'b0;
      case (state)
         ST_GNT0: begin
            mux_tvalid = s0_axis.tvalid;
            mux_tdata  = s0_axis.tdata;
            mux_tkeep  = s0_axis.tkeep;
            mux_tlast  = s0_axis.tlast;
            mux_tuser  = s0_axis.tuser;
            s0_rdy     = m_axis.tready;
         end
         ST_GNT1: begin
            mux_tvalid = s1_axis.tvalid;
            mux_tdata  = s1_axis.tdata;
            mux_tkeep  = s1_axis.tkeep;
            mux_tlast  = s1_axis.tlast;
            mux_tuser  = s1_axis.tuser;
            s1_rdy     = m_axis.tready;
         end
         default: ;
      endcase
   end

   assign m_axis.tvalid  = mux_tvalid;
   assign m_axis.tdata   = mux_tdata;
   assign m_axis.tkeep   = mux_tkeep;
   assign m_axis.tlast   = mux_tlast;
   assign m_axis.tuser   = mux_tuser;
   assign s0_axis.tready = s0_rdy;
   assign s1_axis.tready = s1_rdy;

   assign tlast_acc = mux_tvalid & m_axis.tready & mux_tlast;

   // Ownership FSM: grants only from IDLE (and only while TX is up), releases on the accepted
   // tlast so a packet is never cut short by tx_enable dropping.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= ST_IDLE;
         grant    <= GNT_NONE;
         last_s1  <= 1'b1;
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tx_enable) begin
                  if (pick == GNT_S0) begin
                     state   <= ST_GNT0;
                     grant   <= GNT_S0;
                     last_s1 <= 1'b0;
                  end else if (pick == GNT_S1) begin
                     state   <= ST_GNT1;
                     grant   <= GNT_S1;
                     last_s1 <= 1'b1;
                  end
               end
            end
            ST_GNT0: begin
               if (tlast_acc) begin
                  state    <= ST_IDLE;
                  grant    <= GNT_NONE;
                  pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
               end
            end
            ST_GNT1: begin
               if (tlast_acc) begin
                  state    <= ST_IDLE;
                  grant    <= GNT_NONE;
                  pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= GNT_NONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmac_tx_axis_arb.sv
// Directed bench for cmac_tx_axis_arb: single source, round-robin, fixed priority,
// backpressure with tx_enable drop, reset mid-packet, counter wrap (CNT_W=4).
// Sources are driven from per-source packet counters; outputs are sampled on the falling edge.
module tb_cmac_tx_axis_arb;

   localparam int DW = 64;
   localparam int KW = 8;
   localparam int CW = 4;

   logic          aclk;
   logic          aresetn;
   logic          tx_enable;
   logic          prio_mode;
   logic [1:0]    grant;
   logic [CW-1:0] pkt_cnt0;
   logic [CW-1:0] pkt_cnt1;

   cmac_tx_axis_arb_if #(.DATA_W(DW), .KEEP_W(KW)) s0_if ();
   cmac_tx_axis_arb_if #(.DATA_W(DW), .KEEP_W(KW)) s1_if ();
   cmac_tx_axis_arb_if #(.DATA_W(DW), .KEEP_W(KW)) m_if ();

   cmac_tx_axis_arb #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .tx_enable (tx_enable),
      .prio_mode (prio_mode),
      .s0_axis   (s0_if),
      .s1_axis   (s1_if),
      .m_axis    (m_if),
      .grant     (grant),
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Source driver state: packets left, beats per packet, packet index, beat index.
   int s_left[2];
   int s_len[2];
   int s_pkt[2];
   int s_beat[2];

   logic bp_en;
   logic drop_en;
   logic s1_rdy_seen;

   logic [DW-1:0] obs_dat[$];
   logic [9:0]    obs_side[$];
   logic [1:0]    gnt_trace[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] beat_word(input int src, input int pkt, input int beat);
      return 64'hA5A5_0000_0000_0000 | (64'(src) << 16) | (64'(pkt) << 8) | 64'(beat);
   endfunction

   // {tlast, tuser, tkeep} expected for a given beat of a packet of len beats.
   function automatic logic [9:0] side_word(input int len, input int beat);
      logic lst;
      lst = (beat == len - 1);
      return {lst, (beat == 0), (lst ? 8'h0F : 8'hFF)};
   endfunction

   task automatic drive();
      s0_if.tvalid = (s_left[0] > 0);
      s0_if.tdata  = beat_word(0, s_pkt[0], s_beat[0]);
      s0_if.tlast  = (s_beat[0] == s_len[0] - 1);
      s0_if.tkeep  = s0_if.tlast ? 8'h0F : 8'hFF;
      s0_if.tuser  = (s_beat[0] == 0);
      s1_if.tvalid = (s_left[1] > 0);
      s1_if.tdata  = beat_word(1, s_pkt[1], s_beat[1]);
      s1_if.tlast  = (s_beat[1] == s_len[1] - 1);
      s1_if.tkeep  = s1_if.tlast ? 8'h0F : 8'hFF;
      s1_if.tuser  = (s_beat[1] == 0);
   endtask

   task automatic advance(input int i);
      s_beat[i]++;
      if (s_beat[i] == s_len[i]) begin
         s_beat[i] = 0;
         s_pkt[i]++;
         s_left[i]--;
      end
   endtask

   task automatic clear_obs();
      obs_dat.delete();
      obs_side.delete();
      gnt_trace.delete();
      s1_rdy_seen = 1'b0;
   endtask

   task automatic reset_drivers();
      for (int i = 0; i < 2; i++) begin
         s_left[i] = 0;
         s_len[i]  = 1;
         s_pkt[i]  = 0;
         s_beat[i] = 0;
      end
      drive();
   endtask

   task automatic tick();
      logic a0, a1;
      @(negedge aclk);
      a0 = s0_if.tvalid & s0_if.tready;
      a1 = s1_if.tvalid & s1_if.tready;
      gnt_trace.push_back(grant);
      if (s1_if.tready) s1_rdy_seen = 1'b1;
      if (m_if.tvalid & m_if.tready) begin
         obs_dat.push_back(m_if.tdata);
         obs_side.push_back({m_if.tlast, m_if.tuser, m_if.tkeep});
      end
      @(posedge aclk);
      #1;
      if (a0) advance(0);
      if (a1) advance(1);
      if (drop_en && s_beat[0] == 3) tx_enable = 1'b0;
      if (bp_en) m_if.tready = ~m_if.tready;
      drive();
   endtask

   task automatic do_reset();
      aresetn     = 1'b0;
      tx_enable   = 1'b0;
      prio_mode   = 1'b0;
      m_if.tready = 1'b0;
      bp_en       = 1'b0;
      drop_en     = 1'b0;
      reset_drivers();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      clear_obs();
   endtask

   initial begin
      // ---------------- reset state ----------------
      do_reset();
      aresetn     = 1'b0;
      m_if.tready = 1'b1;
      tx_enable   = 1'b1;
      s_left[0] = 1; s_len[0] = 2;
      s_left[1] = 1; s_len[1] = 2;
      drive();
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_s0_tready", 64'(s0_if.tready), 64'd0);
      chk("rst_s1_tready", 64'(s1_if.tready), 64'd0);
      chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
      chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);

      // ---------------- single source, 9 beats ----------------
      do_reset();
      tx_enable = 1'b1; m_if.tready = 1'b1;
      s_left[0] = 1; s_len[0] = 9;
      drive();
      repeat (11) tick();
      chk("t1_gnt_before", 64'(gnt_trace[0]), 64'd0);
      chk("t1_gnt_lat", 64'(gnt_trace[1]), 64'd1);
      chk("t1_gnt_end", 64'(gnt_trace[10]), 64'd0);
      chk("t1_nbeats", 64'(obs_dat.size()), 64'd9);
      for (int i = 0; i < 9 && i < obs_dat.size(); i++) begin
         chk($sformatf("t1_dat[%0d]", i), obs_dat[i], beat_word(0, 0, i));
         chk($sformatf("t1_side[%0d]", i), 64'(obs_side[i]), 64'(side_word(9, i)));
      end
      chk("t1_cnt0", 64'(pkt_cnt0), 64'd1);
      chk("t1_cnt1", 64'(pkt_cnt1), 64'd0);

      // ---------------- round-robin tie, 2-beat packets ----------------
      do_reset();
      tx_enable = 1'b1; m_if.tready = 1'b1;
      s_left[0] = 4; s_len[0] = 2;
      s_left[1] = 4; s_len[1] = 2;
      drive();
      repeat (25) tick();
      chk("t2_gnt[0]", 64'(gnt_trace[0]), 64'd0);
      for (int p = 0; p < 8; p++) begin
         logic [1:0] g;
         g = (p % 2 == 0) ? 2'b01 : 2'b10;
         chk($sformatf("t2_gnt[%0d]", 1 + 3*p), 64'(gnt_trace[1 + 3*p]), 64'(g));
         chk($sformatf("t2_gnt[%0d]", 2 + 3*p), 64'(gnt_trace[2 + 3*p]), 64'(g));
         chk($sformatf("t2_gnt[%0d]", 3 + 3*p), 64'(gnt_trace[3 + 3*p]), 64'd0);
      end
      chk("t2_nbeats", 64'(obs_dat.size()), 64'd16);
      for (int i = 0; i < 16 && i < obs_dat.size(); i++) begin
         chk($sformatf("t2_dat[%0d]", i), obs_dat[i], beat_word((i/2) % 2, (i/2) / 2, i % 2));
      end
      chk("t2_cnt0", 64'(pkt_cnt0), 64'd4);
      chk("t2_cnt1", 64'(pkt_cnt1), 64'd4);

      // ---------------- fixed priority ----------------
      do_reset();
      tx_enable = 1'b1; prio_mode = 1'b1; m_if.tready = 1'b1;
      s_left[0] = 3; s_len[0] = 2;
      s_left[1] = 3; s_len[1] = 2;
      drive();
      repeat (9) tick();
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("t3_gnt[%0d]", 3*p), 64'(gnt_trace[3*p]), 64'd0);
         chk($sformatf("t3_gnt[%0d]", 3*p + 1), 64'(gnt_trace[3*p + 1]), 64'd1);
         chk($sformatf("t3_gnt[%0d]", 3*p + 2), 64'(gnt_trace[3*p + 2]), 64'd1);
      end
      chk("t3_s1_tready", 64'(s1_rdy_seen), 64'd0);
      chk("t3_cnt0", 64'(pkt_cnt0), 64'd3);
      chk("t3_cnt1", 64'(pkt_cnt1), 64'd0);

      // ---------------- backpressure 1010 and tx_enable drop at beat 3 ----------------
      do_reset();
      tx_enable = 1'b1; m_if.tready = 1'b1;
      bp_en = 1'b1; drop_en = 1'b1;
      s_left[0] = 1; s_len[0] = 9;
      drive();
      repeat (30) tick();
      chk("t4_txen_dropped", 64'(tx_enable), 64'd0);
      chk("t4_nbeats", 64'(obs_dat.size()), 64'd9);
      for (int i = 0; i < 9 && i < obs_dat.size(); i++) begin
         chk($sformatf("t4_dat[%0d]", i), obs_dat[i], beat_word(0, 0, i));
         chk($sformatf("t4_side[%0d]", i), 64'(obs_side[i]), 64'(side_word(9, i)));
      end
      chk("t4_cnt0", 64'(pkt_cnt0), 64'd1);
      bp_en = 1'b0; drop_en = 1'b0; m_if.tready = 1'b1;
      s_left[0] = 1;
      drive();
      clear_obs();
      repeat (5) tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_idle_gnt[%0d]", i), 64'(gnt_trace[i]), 64'd0);
      end
      chk("t4_idle_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("t4_idle_tdata", m_if.tdata, 64'd0);
      chk("t4_idle_tkeep", 64'(m_if.tkeep), 64'd0);
      chk("t4_idle_s0_tready", 64'(s0_if.tready), 64'd0);
      tx_enable = 1'b1;
      clear_obs();
      repeat (2) tick();
      chk("t4_reen_gnt0", 64'(gnt_trace[0]), 64'd0);
      chk("t4_reen_gnt1", 64'(gnt_trace[1]), 64'd1);

      // ---------------- reset mid-packet ----------------
      do_reset();
      tx_enable = 1'b1; m_if.tready = 1'b1;
      s_left[1] = 1; s_len[1] = 2;
      drive();
      repeat (3) tick();
      chk("t5_pre_cnt1", 64'(pkt_cnt1), 64'd1);
      s_left[0] = 1; s_len[0] = 9;
      drive();
      for (int k = 0; k < 20 && s_beat[0] != 4; k++) tick();
      chk("t5_at_beat4", 64'(s_beat[0]), 64'd4);
      chk("t5_pre_gnt", 64'(grant), 64'd1);
      chk("t5_pre_tvalid", 64'(m_if.tvalid), 64'd1);
      aresetn = 1'b0;
      #1;
      chk("t5_rst_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("t5_rst_gnt", 64'(grant), 64'd0);
      chk("t5_rst_cnt0", 64'(pkt_cnt0), 64'd0);
      chk("t5_rst_cnt1", 64'(pkt_cnt1), 64'd0);
      chk("t5_rst_s0_tready", 64'(s0_if.tready), 64'd0);
      reset_drivers();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      s_left[0] = 1; s_len[0] = 2;
      s_left[1] = 1; s_len[1] = 2;
      drive();
      clear_obs();
      repeat (2) tick();
      chk("t5_tie_gnt0", 64'(gnt_trace[0]), 64'd0);
      chk("t5_tie_s0", 64'(gnt_trace[1]), 64'd1);

      // ---------------- counter wrap, 17 single-beat s1 packets ----------------
      do_reset();
      tx_enable = 1'b1; m_if.tready = 1'b1;
      s_left[1] = 17; s_len[1] = 1;
      drive();
      repeat (32) tick();
      chk("t6_cnt1_16", 64'(pkt_cnt1), 64'd0);
      repeat (4) tick();
      chk("t6_nbeats", 64'(obs_dat.size()), 64'd17);
      chk("t6_cnt1_17", 64'(pkt_cnt1), 64'd1);
      chk("t6_cnt0", 64'(pkt_cnt0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cmac_tx_axis_arb.md
CMAC_TX_AXIS_ARB -- requirements
Module: cmac_tx_axis_arb

Interface
REQ-001 Parameter DATA_W, default 512, SHALL set the AXIS tdata width.
REQ-002 Parameter KEEP_W, default 64, SHALL set the tkeep width and always equal DATA_W/8.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of each packet counter.
REQ-004 aclk, input, 1 bit: the only clock (CMAC txusrclk2 domain).
REQ-005 aresetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 tx_enable, input, 1 bit: CMAC TX is up (ctl_tx_enable); new grants are allowed only while it is high.
REQ-007 prio_mode, input, 1 bit: 0 = round-robin, 1 = fixed priority with s0 first.
REQ-008 s0_axis_tvalid/tready/tdata/tkeep/tlast/tuser, 1/1/DATA_W/KEEP_W/1/1 bits: ERNIC TX stream in (tready is the only output).
REQ-009 s1_axis_*, same set and widths as s0: packet-generator stream in.
REQ-010 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser, same widths: stream out to CMAC tx_axis (tready is the only input).
REQ-011 grant, output, 2 bits: one-hot current owner, where bit0 = s0, bit1 = s1, 00 = idle.
REQ-012 pkt_cnt0, pkt_cnt1, output, CNT_W bits each: count of completed packets per source.

Function
REQ-013 The FSM SHALL have three states: IDLE, GNT0 and GNT1.
REQ-014 In IDLE, with tx_enable=1: go to GNT0 or GNT1 on the next edge, chosen per REQ-015/016. With tx_enable=0, stay in IDLE.
REQ-015 Round-robin: if both sources have tvalid=1, grant the source that was not granted last. The last-granted source SHALL be initialised to s1, so s0 wins the first tie.
REQ-016 Fixed priority: s0 wins whenever s0_axis_tvalid=1.
REQ-017 In GNTx, m_axis_* SHALL be a combinational pass-through of sx_axis_*, and sx_axis_tready = m_axis_tready. This is zero latency.
REQ-018 The non-granted source's tready SHALL be 0, and all tready outputs SHALL be 0 in IDLE.
REQ-019 In IDLE, m_axis_tvalid, tlast and tuser SHALL be 0, and tdata and tkeep SHALL be all-zero.
REQ-020 A beat is accepted when m_axis_tvalid & m_axis_tready.
REQ-021 When a tlast beat is accepted, the FSM SHALL return to IDLE. This gives exactly one bubble cycle between packets.
REQ-022 The grant SHALL hold until tlast is accepted. Deasserting tx_enable mid-packet SHALL NOT truncate or abort the packet.
REQ-023 pkt_cntx SHALL increment by 1 on each accepted tlast beat from source x.
REQ-024 Each counter SHALL wrap from 2^CNT_W-1 to 0.
REQ-025 Grant changes SHALL occur only in IDLE. A tvalid rising on the other source during a packet has no effect until IDLE.
REQ-026 The last-granted record SHALL update on IDLE->GNTx.
REQ-027 grant SHALL be registered and SHALL reflect the state directly.

Reset
REQ-028 When aresetn=0, the block SHALL asynchronously set: state = IDLE, grant = 00, last-granted = s1, and pkt_cnt0 = pkt_cnt1 = 0.
REQ-029 During reset, all tready outputs and m_axis_tvalid SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet. After release, arbitration SHALL restart from IDLE.
REQ-031 aresetn SHALL be released synchronously to aclk outside this block.

Structure
REQ-032 The state encoding, DATA_W/KEEP_W defaults and grant encoding constants SHALL live in the shared package cmac_tx_pkg.
REQ-033 One sub-module, cmac_tx_rr_pick, SHALL hold the 2-request priority and round-robin select logic as purely combinational logic.
REQ-034 The FSM, mux and counters SHALL reside in cmac_tx_axis_arb.

Verification
REQ-035 Single source:
- Stimulus: tx_enable=1, prio_mode=0, s0 sends a 9-beat packet, m_tready=1.
- Response: grant=01 one cycle after s0_tvalid, 9 beats out unchanged, then grant=00, pkt_cnt0=1.
REQ-036 Round-robin tie:
- Stimulus: both sources continuously valid with 2-beat packets, prio_mode=0.
- Response: order s0,s1,s0,s1 with one idle cycle between packets; after 8 packets, pkt_cnt0=4 and pkt_cnt1=4.
REQ-037 Fixed priority:
- Stimulus: same as REQ-036 with prio_mode=1.
- Response: only s0 is served, s1_tready stays 0, and pkt_cnt1=0.
REQ-038 Backpressure and disable:
- Stimulus: m_tready toggles 1010 mid-packet, and tx_enable drops at beat 3 of 9.
- Response: all 9 beats are delivered in order with no duplication, then the FSM stays in IDLE while tx_enable=0.
REQ-039 Reset mid-packet:
- Stimulus: aresetn=0 at beat 4.
- Response: m_tvalid=0, grant=00 and counters 0 in the same cycle; after release, s0 wins a tie.
REQ-040 Wrap:
- Stimulus: CNT_W=4, 17 s1 packets.
- Response: pkt_cnt1=1.
